// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/interrupt sequencer:
// cause codes, CP0 status bit positions and the FSM state encoding.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

    localparam logic [4:0] CAUSE_SYS_DEF = 5'd8;
    localparam logic [4:0] CAUSE_BRK_DEF = 5'd9;
    localparam logic [4:0] CAUSE_TEQ_DEF = 5'd13;
    localparam logic [4:0] CAUSE_INT_DEF = 5'd0;

    // CP0 status bit positions used for masking
    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_INT = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAKE = 3'd1,
        S_VEC  = 3'd2,
        S_ERET = 3'd3,
        S_RET  = 3'd4
    } exc_state_e;

endpackage

// File: rtl/exc_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous external interrupt level.
module exc_ctrl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two register stages; first stage may go metastable, second is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the multi-cycle CPU control unit
// and the CP0 register file. Detects masked traps/interrupts at instruction
// boundaries, pulses the CP0 strobes and redirects the PC.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | running; detect events on instr_done, pass mtc0 through
// TAKE  | pulse cp0_exception with latched cause and pc, stall CPU
// VEC   | redirect PC to the exception vector
// ERET  | pulse cp0_eret, capture EPC from CP0, stall CPU
// RET   | redirect PC to the captured EPC
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [4:0]  CAUSE_SYS  = CAUSE_SYS_DEF,
    parameter logic [4:0]  CAUSE_BRK  = CAUSE_BRK_DEF,
    parameter logic [4:0]  CAUSE_TEQ  = CAUSE_TEQ_DEF,
    parameter logic [4:0]  CAUSE_INT  = CAUSE_INT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_done,
    input  logic [31:0] pc,
    input  logic        sys_req,
    input  logic        brk_req,
    input  logic        teq_req,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic        intr,
    input  logic        timer_int,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
    output logic        cp0_exception,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_epc,
    output logic        cp0_eret,
    output logic        cp0_mtc0,
    output logic        cpu_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    exc_state_e  state_q, state_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;

    logic intr_sync;
    logic glb_en;
    logic teq_hit, brk_hit, sys_hit, int_hit;
    logic evt_trap, evt_eret, evt_int;
    logic [4:0] evt_cause;
    logic unused_status;

    exc_ctrl_sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d_i (intr),
        .q_o (intr_sync)
    );

    // Upper status bits belong to CP0 and are not used here.
    assign unused_status = ^status[31:5];

    // Status is only sampled in IDLE, so the shift CP0 applies at the
    // TAKE/ERET edge cannot retrigger before the redirect completes.
    assign glb_en  = status[ST_IE];
    assign teq_hit = glb_en & status[ST_TEQ] & teq_req;
    assign brk_hit = glb_en & status[ST_BRK] & brk_req;
    assign sys_hit = glb_en & status[ST_SYS] & sys_req;
    assign int_hit = glb_en & status[ST_INT] & (intr_sync | timer_int);

    assign evt_trap = instr_done & (teq_hit | brk_hit | sys_hit);
    assign evt_eret = instr_done & eret_req & ~evt_trap;
    assign evt_int  = instr_done & int_hit & ~evt_trap & ~eret_req;

    // Fixed priority teq > brk > sys; interrupts only when no trap won.
    always_comb begin
        evt_cause = CAUSE_INT;
        if (teq_hit) begin
            evt_cause = CAUSE_TEQ;
        end else if (brk_hit) begin
            evt_cause = CAUSE_BRK;
        end else if (sys_hit) begin
            evt_cause = CAUSE_SYS;
        end
    end

    // State and latched exception context; reset abandons any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cause_q <= 5'd0;
            pc_q    <= 32'd0;
            epc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // Next-state and strobe generation.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        pc_d           = pc_q;
        epc_d          = epc_q;
        cp0_exception  = 1'b0;
        cp0_cause      = 5'd0;
        cp0_epc        = 32'd0;
        cp0_eret       = 1'b0;
        cp0_mtc0       = 1'b0;
        cpu_stall      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        case (state_q)
            S_IDLE: begin
                // Gated by rst so the detect-cycle stall and the mtc0
                // pass-through also read 0 while reset is held.
                if (!rst) begin
                    if (evt_trap || evt_int) begin
                        state_d   = S_TAKE;
                        cause_d   = evt_cause;
                        pc_d      = pc;
                        cpu_stall = 1'b1;
                    end else if (evt_eret) begin
                        state_d   = S_ERET;
                        cpu_stall = 1'b1;
                    end else begin
                        // CP0 favours mtc0, so it only passes with no event.
                        cp0_mtc0 = mtc0_req;
                    end
                end
            end
            S_TAKE: begin
                cp0_exception = 1'b1;
                cp0_cause     = cause_q;
                cp0_epc       = pc_q;
                cpu_stall     = 1'b1;
                state_d       = S_VEC;
            end
            S_VEC: begin
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
                state_d        = S_IDLE;
            end
            S_ERET: begin
                cp0_eret  = 1'b1;
                cpu_stall = 1'b1;
                epc_d     = exc_addr;
                state_d   = S_RET;
            end
            S_RET: begin
                redirect_valid = 1'b1;
                redirect_pc    = epc_q;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer sitting between the multi-cycle CPU control unit and the CP0 register file.
- Collects synchronous traps (syscall, break, teq) and asynchronous sources (external intr, timer_int), then masks them against CP0 status.
- Prioritises them and drives the CP0 exception/eret/mtc0 strobes, each as a single-cycle pulse.
- Stalls the CPU and issues a PC redirect (exception vector, or EPC on eret).

Parameters:
- EXC_VECTOR, 32'h0040_0004, handler entry address.
- CAUSE_SYS, 5'd8, syscall cause code.
- CAUSE_BRK, 5'd9, break cause code.
- CAUSE_TEQ, 5'd13, trap-equal cause code.
- CAUSE_INT, 5'd0, interrupt cause code (external and timer).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- instr_done  in  1  current instruction completes this cycle (instruction boundary).
- pc  in  32  address of current instruction.
- sys_req  in  1  syscall decoded; valid only with instr_done.
- brk_req  in  1  break decoded; valid only with instr_done.
- teq_req  in  1  teq condition true; valid only with instr_done.
- eret_req  in  1  eret decoded; valid only with instr_done.
- mtc0_req  in  1  CPU mtc0 request.
- intr  in  1  external interrupt, asynchronous, level.
- timer_int  in  1  CP0 timer interrupt, level.
- status  in  32  CP0 status register.
- exc_addr  in  32  CP0 EPC output (valid while eret high).
- cp0_exception  out  1  exception strobe to CP0.
- cp0_cause  out  5  cause code to CP0.
- cp0_epc  out  32  pc to CP0.
- cp0_eret  out  1  eret strobe to CP0.
- cp0_mtc0  out  1  gated mtc0 strobe to CP0.
- cpu_stall  out  1  freeze PC/IR update.
- redirect_valid  out  1  load redirect_pc into PC this cycle.
- redirect_pc  out  32  target address.

Behaviour:
- Masks, using status bits [4:0]:
  - status[0] is the global enable; no trap or interrupt is taken when it is 0.
  - status[1] enables sys, [2] brk, [3] teq, [4] interrupts.
  - eret is never masked.
- Input synchroniser: intr passes through a 2-flop synchroniser before use. timer_int is used directly.
- Priority among events qualified by instr_done: teq > brk > sys > eret > interrupt.
  - The interrupt is taken only on instr_done with no enabled synchronous trap and no eret pending.
  - A disabled trap is ignored: execution continues and no stall occurs.
- FSM states: IDLE, TAKE, VEC, ERET, RET.
  - IDLE: on a qualified trap or interrupt, latch cause and pc (the interrupting instruction's pc), go to TAKE. On a qualified eret, go to ERET.
  - TAKE: cp0_exception=1, cp0_cause=latched cause, cp0_epc=latched pc for exactly 1 cycle. Go to VEC.
  - VEC: redirect_valid=1, redirect_pc=EXC_VECTOR for 1 cycle. Go to IDLE.
  - ERET: cp0_eret=1 for 1 cycle; register exc_addr into epc_q. Go to RET.
  - RET: redirect_valid=1, redirect_pc=epc_q. Go to IDLE.
- cpu_stall rules:
  - cpu_stall=1 in TAKE, ERET and any detect cycle (combinational from IDLE-state detection).
  - cpu_stall=0 in VEC and RET, so the PC loads the redirect.
- Fixed latency: trap detect to redirect is 2 cycles.
- mtc0 gating: cp0_mtc0 = mtc0_req only in IDLE with no event detected. In all other states it is forced to 0, because CP0 gives mtc0 priority and would otherwise drop the exception.
- Status update timing: CP0 shifts status at the TAKE/ERET edge. The FSM must not re-sample status before VEC completes.
- A level interrupt still asserted after the handler entry is masked by the shifted status. No re-entry until eret.
- Output defaults: all strobes 0 outside their states. redirect_pc=0 when redirect_valid=0. cp0_cause and cp0_epc are 0 outside TAKE.
- Reset (asynchronous, any state): state=IDLE, synchroniser flops and latched cause/pc/epc_q=0, all outputs 0. An operation in flight is abandoned and no partial strobe is emitted.

Decomposition:
- Shared package: cause codes, status bit-index constants, FSM state encoding.
- Natural sub-module: sync2 (2-flop synchroniser for intr).

Test Plan:
- status=32'h3, sys_req and instr_done at pc=32'h0040_0100 -> next cycle cp0_exception=1, cp0_cause=8, cp0_epc=32'h0040_0100; following cycle redirect_valid=1, redirect_pc=32'h0040_0004.
- status=32'h1, brk_req and instr_done -> no strobes, cpu_stall=0 (masked).
- status=32'h1F, teq_req and sys_req and synced intr all with instr_done -> cp0_cause=13, single exception pulse.
- eret_req with CP0 EPC=32'h0040_0200 -> cp0_eret for 1 cycle, then redirect_pc=32'h0040_0200; CP0 status shifted right by 5.
- mtc0_req coincident with sys_req (enabled) -> cp0_mtc0=0 in all cycles, exception recorded correctly; an isolated mtc0_req in IDLE passes through.
- rst asserted in TAKE -> all outputs 0 immediately, state IDLE; pending intr held high with status=32'h11 after release -> interrupt taken at the first instr_done, cause=0.
